// File: rtl/gpio_link_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gpio_link_pkg
//  Description : Shared types and default parameters for the inter-board
//                button link receiver (gpio_to_mouse and its channel filter).
//                - btn_state_t        : per-channel debounce state
//                - GPIO_SYNC_STAGES   : default synchronizer depth
//                - GPIO_FILTER_CYCLES : default glitch-filter hold time
//  Revision    : 1.0  initial release
// ============================================================================
package gpio_link_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int GPIO_SYNC_STAGES   = 2;
    localparam int GPIO_FILTER_CYCLES = 16;

endpackage : gpio_link_pkg
`default_nettype wire

// File: rtl/gpio_to_mouse_if.sv
`default_nettype none
// ============================================================================
//  Interface   : gpio_to_mouse_if
//  Description : Bundle of the two raw button lines coming from the peer
//                board and the cleaned-up button state produced locally.
//                master : peer side, drives the raw GPIO lines and observes
//                         the filtered levels and strobes
//                slave  : receiver (gpio_to_mouse), samples the raw lines and
//                         drives levels and strobes
//  Signals     : gpio_left_in/gpio_right_in  raw lines (async to clk)
//                m_left/m_right              filtered levels (1 = pressed)
//                left_press/left_release     1-cycle strobes, left channel
//                right_press/right_release   1-cycle strobes, right channel
//  Revision    : 1.0  initial release
// ============================================================================
interface gpio_to_mouse_if;

    logic gpio_left_in;
    logic gpio_right_in;
    logic m_left;
    logic m_right;
    logic left_press;
    logic left_release;
    logic right_press;
    logic right_release;

    modport master (
        output gpio_left_in,
        output gpio_right_in,
        input  m_left,
        input  m_right,
        input  left_press,
        input  left_release,
        input  right_press,
        input  right_release
    );

    modport slave (
        input  gpio_left_in,
        input  gpio_right_in,
        output m_left,
        output m_right,
        output left_press,
        output left_release,
        output right_press,
        output right_release
    );

endinterface : gpio_to_mouse_if
`default_nettype wire

// File: rtl/gpio_btn_filter.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_btn_filter
//  Description : One button channel: metastability synchronizer, glitch
//                filter (a new level must hold FILTER_CYCLES consecutive
//                cycles) and registered press/release strobes.
//  Ports       : clk            in   system clock
//                rst_n          in   asynchronous active-low reset
//                line_async     in   raw line, asynchronous to clk
//                level          out  filtered level (1 = pressed)
//                press_pulse    out  1-cycle strobe on level 0->1
//                release_pulse  out  1-cycle strobe on level 1->0
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_btn_filter
    import gpio_link_pkg::*;
#(
    parameter int SYNC_STAGES   = GPIO_SYNC_STAGES,
    parameter int FILTER_CYCLES = GPIO_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_async,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    // Counter only ever reaches FILTER_CYCLES-1, so this width cannot wrap.
    localparam int              CNT_W       = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    // With a one-cycle filter the pending states are skipped entirely.
    localparam bit              c_direct    = (FILTER_CYCLES == 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("gpio_btn_filter: SYNC_STAGES must be >= 2");
        end
        if (FILTER_CYCLES < 1) begin : g_bad_filter
            $error("gpio_btn_filter: FILTER_CYCLES must be >= 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    btn_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    // Synchronizer: bit 0 takes the raw line, the top bit is the sampled line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], line_async};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Debounce FSM. The counter holds how many consecutive cycles the
    // candidate level has been seen; any return to the current level
    // drops back to the stable state and discards the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (w_s) begin
                        if (c_direct) begin
                            r_state <= PRESSED;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_state <= PRESS_PEND;
                            r_cnt   <= c_cnt_one;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!w_s) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_s) begin
                        if (c_direct) begin
                            r_state   <= RELEASED;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_state <= RELEASE_PEND;
                            r_cnt   <= c_cnt_one;
                        end
                    end
                end
                RELEASE_PEND: begin
                    if (w_s) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state   <= RELEASED;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign level         = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule : gpio_btn_filter
`default_nettype wire

// File: rtl/gpio_to_mouse.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_to_mouse
//  Description : Receiving end of the inter-board button link. Two fully
//                independent channels (left, right) each synchronize,
//                debounce and edge-detect one raw GPIO line.
//  Ports       : clk    in   system clock
//                rst_n  in   asynchronous active-low reset
//                link   gpio_to_mouse_if.slave
//                       gpio_left_in/gpio_right_in in, m_left/m_right out,
//                       left_press/left_release/right_press/right_release out
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_to_mouse
    import gpio_link_pkg::*;
#(
    parameter int SYNC_STAGES   = GPIO_SYNC_STAGES,
    parameter int FILTER_CYCLES = GPIO_FILTER_CYCLES
) (
    input  logic           clk,
    input  logic           rst_n,
    gpio_to_mouse_if.slave link
);

    gpio_btn_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_left (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_async    (link.gpio_left_in),
        .level         (link.m_left),
        .press_pulse   (link.left_press),
        .release_pulse (link.left_release)
    );

    gpio_btn_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_right (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_async    (link.gpio_right_in),
        .level         (link.m_right),
        .press_pulse   (link.right_press),
        .release_pulse (link.right_release)
    );

endmodule : gpio_to_mouse
`default_nettype wire

// File: tb/tb_gpio_to_mouse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_to_mouse
//  Description : Self-checking bench. dut0 uses default parameters, dut1 uses
//                SYNC_STAGES=3 / FILTER_CYCLES=1; both see the same lines.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_to_mouse;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pin_l = 1'b0;
    logic pin_r = 1'b0;

    always #5 clk = ~clk;

    gpio_to_mouse_if bus0 ();
    gpio_to_mouse_if bus1 ();

    assign bus0.gpio_left_in  = pin_l;
    assign bus0.gpio_right_in = pin_r;
    assign bus1.gpio_left_in  = pin_l;
    assign bus1.gpio_right_in = pin_r;

    gpio_to_mouse #(.SYNC_STAGES(2), .FILTER_CYCLES(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .link(bus0.slave));
    gpio_to_mouse #(.SYNC_STAGES(3), .FILTER_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .link(bus1.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model -----------------------------------
    // Index i = dut*2 + channel. A line value reaches the filter after
    // sync_of() clock edges; the level flips once the last filt_of() samples
    // all disagree with it, and a strobe marks that edge.
    bit sq [4][$];
    bit wq [4][$];
    bit lvl [4];
    bit prs [4];
    bit rls [4];

    function automatic int sync_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction
    function automatic int filt_of(input int d);
        return (d == 0) ? 16 : 1;
    endfunction

    function void model_reset();
        for (int i = 0; i < 4; i++) begin
            sq[i].delete();
            wq[i].delete();
            for (int k = 0; k < sync_of(i / 2); k++) sq[i].push_back(1'b0);
            for (int k = 0; k < filt_of(i / 2); k++) wq[i].push_back(1'b0);
            lvl[i] = 1'b0;
            prs[i] = 1'b0;
            rls[i] = 1'b0;
        end
    endfunction

    function void model_step(input bit l, input bit r);
        for (int i = 0; i < 4; i++) begin
            bit s;
            bit flip;
            s = sq[i].pop_front();
            sq[i].push_back((i % 2 == 0) ? l : r);
            wq[i].push_back(s);
            void'(wq[i].pop_front());
            flip = 1'b1;
            for (int k = 0; k < wq[i].size(); k++)
                if (wq[i][k] == lvl[i]) flip = 1'b0;
            prs[i] = 1'b0;
            rls[i] = 1'b0;
            if (flip) begin
                lvl[i] = !lvl[i];
                if (lvl[i]) prs[i] = 1'b1;
                else        rls[i] = 1'b1;
            end
        end
    endfunction

    function automatic logic [5:0] model_vec(input int d);
        return {lvl[2*d], lvl[2*d+1], prs[2*d], rls[2*d], prs[2*d+1], rls[2*d+1]};
    endfunction

    logic [5:0] vec0, vec1;
    assign vec0 = {bus0.m_left, bus0.m_right, bus0.left_press, bus0.left_release,
                   bus0.right_press, bus0.right_release};
    assign vec1 = {bus1.m_left, bus1.m_right, bus1.left_press, bus1.left_release,
                   bus1.right_press, bus1.right_release};

    // One clock: model follows the edge, both DUTs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(pin_l, pin_r);
        #1;
        check("model_dut0", 32'(vec0), 32'(model_vec(0)));
        check("model_dut1", 32'(vec1), 32'(model_vec(1)));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_dut0", 32'(vec0), 32'd0);
        check("reset_dut1", 32'(vec1), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        pin_l = 1'b0;
        pin_r = 1'b0;
        repeat (n) tick();
    endtask

    // ---------------- table-driven vectors (dut0) -----------------------
    typedef struct {
        bit l;
        bit r;
        int hold;
        bit ml;
        bit mr;
        int lp;
        int lr;
        int rp;
        int rr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lp, lr, rp, rr, t_a, t_b;
        bit bp [8];

        tbl[0] = '{l:1, r:0, hold:17, ml:0, mr:0, lp:0, lr:0, rp:0, rr:0};
        tbl[1] = '{l:1, r:0, hold:1,  ml:1, mr:0, lp:1, lr:0, rp:0, rr:0};
        tbl[2] = '{l:1, r:1, hold:20, ml:1, mr:1, lp:0, lr:0, rp:1, rr:0};
        tbl[3] = '{l:0, r:1, hold:18, ml:0, mr:1, lp:0, lr:1, rp:0, rr:0};
        tbl[4] = '{l:0, r:0, hold:15, ml:0, mr:1, lp:0, lr:0, rp:0, rr:0};
        tbl[5] = '{l:1, r:1, hold:20, ml:1, mr:1, lp:1, lr:0, rp:0, rr:0};
        tbl[6] = '{l:0, r:0, hold:18, ml:0, mr:0, lp:0, lr:1, rp:0, rr:1};
        tbl[7] = '{l:0, r:0, hold:5,  ml:0, mr:0, lp:0, lr:0, rp:0, rr:0};

        model_reset();
        apply_reset();
        idle(20);

        for (int e = 0; e < 8; e++) begin
            pin_l = tbl[e].l;
            pin_r = tbl[e].r;
            lp = 0; lr = 0; rp = 0; rr = 0;
            for (int c = 0; c < tbl[e].hold; c++) begin
                tick();
                lp += int'(bus0.left_press);
                lr += int'(bus0.left_release);
                rp += int'(bus0.right_press);
                rr += int'(bus0.right_release);
            end
            check($sformatf("tbl%0d_levels", e), {30'd0, bus0.m_left, bus0.m_right},
                  {30'd0, tbl[e].ml, tbl[e].mr});
            check($sformatf("tbl%0d_strobes", e), {lp[7:0], lr[7:0], rp[7:0], rr[7:0]},
                  {tbl[e].lp[7:0], tbl[e].lr[7:0], tbl[e].rp[7:0], tbl[e].rr[7:0]});
        end

        // Reset mid-press-pending, with the right channel already pressed.
        idle(20);
        pin_r = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            if (c == 20) pin_l = 1'b1;
            tick();
        end
        check("pre_reset_m_right", 32'(bus0.m_right), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_outputs", 32'(vec0), 32'd0);
        pin_r = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        t_a = 0; lp = 0; lr = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus0.left_press) begin
                lp++;
                if (t_a == 0) t_a = c;
            end
            lr += int'(bus0.left_release);
        end
        check("reset_release_press_cycle", t_a, 18);
        check("reset_release_press_count", lp, 1);
        check("reset_release_no_release", lr, 0);
        check("reset_release_m_left", 32'(bus0.m_left), 32'd1);

        // Glitch rejection: 15-cycle pulse vanishes, 16-cycle pulse passes.
        idle(25);
        pin_r = 1'b1;
        rp = 0; rr = 0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 16) pin_r = 1'b0;
            tick();
            rp += int'(bus0.right_press);
            rr += int'(bus0.right_release);
        end
        check("glitch15_strobes", {rp[15:0], rr[15:0]}, 32'd0);
        check("glitch15_m_right", 32'(bus0.m_right), 32'd0);
        pin_r = 1'b1;
        t_a = 0; t_b = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 17) pin_r = 1'b0;
            tick();
            if (bus0.right_press   && t_a == 0) t_a = c;
            if (bus0.right_release && t_b == 0) t_b = c;
        end
        check("pulse16_press_cycle", t_a, 18);
        check("pulse16_release_gap", t_b - t_a, 16);

        // Bounce, then stable high from tick 9.
        idle(25);
        bp = '{1, 0, 0, 1, 0, 1, 1, 0};
        lp = 0; t_a = 0;
        for (int c = 1; c <= 40; c++) begin
            pin_l = (c <= 8) ? bp[c-1] : 1'b1;
            tick();
            if (bus0.left_press) begin
                lp++;
                if (t_a == 0) t_a = c;
            end
        end
        check("bounce_press_count", lp, 1);
        check("bounce_press_cycle", t_a - 8, 18);

        // Simultaneous press, releases 7 cycles apart.
        idle(25);
        pin_l = 1'b1;
        pin_r = 1'b1;
        t_a = 0; t_b = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (bus0.left_press  && t_a == 0) t_a = c;
            if (bus0.right_press && t_b == 0) t_b = c;
        end
        check("simul_left_press_cycle", t_a, 18);
        check("simul_right_press_cycle", t_b, 18);
        t_a = 0; t_b = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) pin_l = 1'b0;
            if (c == 8) pin_r = 1'b0;
            tick();
            if (bus0.left_release  && t_a == 0) t_a = c;
            if (bus0.right_release && t_b == 0) t_b = c;
        end
        check("simul_left_release_cycle", t_a, 18);
        check("simul_release_gap", t_b - t_a, 7);

        // One-cycle filter instance: 1-cycle pulse passes after 4 cycles.
        idle(25);
        pin_l = 1'b1;
        t_a = 0; t_b = 0; lp = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 2) pin_l = 1'b0;
            tick();
            if (bus1.left_press   && t_a == 0) t_a = c;
            if (bus1.left_release && t_b == 0) t_b = c;
            lp += int'(bus0.left_press);
        end
        check("fast_press_cycle", t_a, 4);
        check("fast_release_cycle", t_b, 5);
        check("fast_pulse_ignored_dut0", lp, 0);

        // Randomized segments with occasional reset, checked against the model.
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 39) == 0) apply_reset();
            pin_l = 1'($urandom_range(0, 1));
            pin_r = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 24)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_gpio_to_mouse
`default_nettype wire
